// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: owns mtime/mtimecmp, takes timer interrupts, ecall
// traps and mret, writing mepc/mcause/mstatus one per cycle before redirecting the PC.
module trap_ctrl #(
  parameter int                XLEN         = 64,
  parameter int                MTIME_DIV    = 1,
  parameter logic [XLEN-1:0]   MTIMECMP_RST = {XLEN{1'b1}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  input  logic [XLEN-1:0] pc,
  input  logic            is_ecall,
  input  logic            is_mret,
  input  logic [XLEN-1:0] mstatus_in,
  input  logic            mie_mtie,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  input  logic            mtimecmp_wen,
  input  logic [XLEN-1:0] mtimecmp_wdata,
  output logic            stall,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            csr_wen,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] mtime,
  output logic            mtip
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] EPC     = 3'd1;
  localparam logic [2:0] CAUSE   = 3'd2;
  localparam logic [2:0] STATUS  = 3'd3;
  localparam logic [2:0] MRET_ST = 3'd4;
  localparam logic [2:0] JUMP    = 3'd5;

  localparam int              PW          = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX     = PW'(MTIME_DIV - 1);
  localparam logic [XLEN-1:0] CAUSE_IRQ   = {1'b1, {(XLEN-4){1'b0}}, 3'd7};
  localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] saved_pc_q, saved_pc_d;
  logic [XLEN-1:0] saved_cause_q, saved_cause_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [PW-1:0]   prescaler_q;
  logic [XLEN-1:0] mtime_q, mtimecmp_q;
  logic            mtip_q;
  logic            irq;

  assign irq   = mtip_q & mie_mtie & mstatus_in[3];
  assign mtime = mtime_q;
  assign mtip  = mtip_q;

  always_comb begin
    state_d       = state_q;
    saved_pc_d    = saved_pc_q;
    saved_cause_d = saved_cause_q;
    target_d      = target_q;
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = '0;
    csr_wen       = 1'b0;
    csr_waddr     = 12'h000;
    csr_wdata     = '0;
    case (state_q)
      IDLE: begin
        // Interrupt outranks ecall, which in turn outranks mret.
        if (inst_valid) begin
          if (irq) begin
            saved_pc_d    = pc;
            saved_cause_d = CAUSE_IRQ;
            state_d       = EPC;
            stall         = 1'b1;
          end else if (is_ecall) begin
            saved_pc_d    = pc;
            saved_cause_d = CAUSE_ECALL;
            state_d       = EPC;
            stall         = 1'b1;
          end else if (is_mret) begin
            state_d       = MRET_ST;
            stall         = 1'b1;
          end
        end
      end
      EPC: begin
        stall     = 1'b1;
        csr_wen   = 1'b1;
        csr_waddr = 12'h341;
        csr_wdata = saved_pc_q;
        state_d   = CAUSE;
      end
      CAUSE: begin
        stall     = 1'b1;
        csr_wen   = 1'b1;
        csr_waddr = 12'h342;
        csr_wdata = saved_cause_q;
        state_d   = STATUS;
      end
      STATUS: begin
        stall            = 1'b1;
        csr_wen          = 1'b1;
        csr_waddr        = 12'h300;
        csr_wdata        = mstatus_in;
        csr_wdata[7]     = mstatus_in[3];
        csr_wdata[3]     = 1'b0;
        csr_wdata[12:11] = 2'b11;
        target_d         = mtvec_in & ~XLEN'(3);
        state_d          = JUMP;
      end
      MRET_ST: begin
        stall            = 1'b1;
        csr_wen          = 1'b1;
        csr_waddr        = 12'h300;
        csr_wdata        = mstatus_in;
        csr_wdata[3]     = mstatus_in[7];
        csr_wdata[7]     = 1'b1;
        csr_wdata[12:11] = 2'b11;
        target_d         = mepc_in;
        state_d          = JUMP;
      end
      JUMP: begin
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = target_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      saved_pc_q    <= '0;
      saved_cause_q <= '0;
      target_q      <= '0;
    end else begin
      state_q       <= state_d;
      saved_pc_q    <= saved_pc_d;
      saved_cause_q <= saved_cause_d;
      target_q      <= target_d;
    end
  end

  // mtip compares the pre-update register values, so it lags mtime by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= MTIMECMP_RST;
      mtip_q      <= 1'b0;
    end else begin
      if (prescaler_q == PRE_MAX) begin
        prescaler_q <= '0;
        mtime_q     <= mtime_q + XLEN'(1);
      end else begin
        prescaler_q <= prescaler_q + PW'(1);
      end
      if (mtimecmp_wen)
        mtimecmp_q <= mtimecmp_wdata;
      mtip_q <= (mtime_q >= mtimecmp_q);
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: ecall, mret, timer interrupt, priority, prescaler,
// mtime wrap and mid-sequence reset.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0;
  logic [63:0] pc = '0;
  logic        is_ecall = 1'b0;
  logic        is_mret = 1'b0;
  logic [63:0] mstatus_in = '0;
  logic        mie_mtie = 1'b0;
  logic [63:0] mtvec_in = '0;
  logic [63:0] mepc_in = '0;
  logic        mtimecmp_wen = 1'b0;
  logic [63:0] mtimecmp_wdata = '0;
  logic        stall, redirect, csr_wen, mtip;
  logic [63:0] redirect_pc, csr_wdata, mtime;
  logic [11:0] csr_waddr;

  logic        rst_b = 1'b1;
  logic        b_stall, b_redirect, b_csr_wen, b_mtip;
  logic [63:0] b_redirect_pc, b_csr_wdata, b_mtime;
  logic [11:0] b_csr_waddr;

  logic        rst_c = 1'b1;
  logic        c_wen = 1'b0;
  logic [12:0] c_wdata = '0;
  logic        c_stall, c_redirect, c_csr_wen, c_mtip;
  logic [12:0] c_redirect_pc, c_csr_wdata, c_mtime;
  logic [11:0] c_csr_waddr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(64), .MTIME_DIV(1)) u_a (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc(pc), .is_ecall(is_ecall),
    .is_mret(is_mret), .mstatus_in(mstatus_in), .mie_mtie(mie_mtie), .mtvec_in(mtvec_in),
    .mepc_in(mepc_in), .mtimecmp_wen(mtimecmp_wen), .mtimecmp_wdata(mtimecmp_wdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .csr_wen(csr_wen),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .mtime(mtime), .mtip(mtip)
  );

  trap_ctrl #(.XLEN(64), .MTIME_DIV(4)) u_b (
    .clk(clk), .rst(rst_b), .inst_valid(1'b0), .pc(64'd0), .is_ecall(1'b0),
    .is_mret(1'b0), .mstatus_in(64'd0), .mie_mtie(1'b0), .mtvec_in(64'd0),
    .mepc_in(64'd0), .mtimecmp_wen(1'b0), .mtimecmp_wdata(64'd0),
    .stall(b_stall), .redirect(b_redirect), .redirect_pc(b_redirect_pc), .csr_wen(b_csr_wen),
    .csr_waddr(b_csr_waddr), .csr_wdata(b_csr_wdata), .mtime(b_mtime), .mtip(b_mtip)
  );

  trap_ctrl #(.XLEN(13), .MTIME_DIV(1)) u_c (
    .clk(clk), .rst(rst_c), .inst_valid(1'b0), .pc(13'd0), .is_ecall(1'b0),
    .is_mret(1'b0), .mstatus_in(13'd0), .mie_mtie(1'b0), .mtvec_in(13'd0),
    .mepc_in(13'd0), .mtimecmp_wen(c_wen), .mtimecmp_wdata(c_wdata),
    .stall(c_stall), .redirect(c_redirect), .redirect_pc(c_redirect_pc), .csr_wen(c_csr_wen),
    .csr_waddr(c_csr_waddr), .csr_wdata(c_csr_wdata), .mtime(c_mtime), .mtip(c_mtip)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_valid = 1'b0;
    is_ecall   = 1'b0;
    is_mret    = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_redirect", {63'd0, redirect}, 64'd0);
    check("rst_csr_wen", {63'd0, csr_wen}, 64'd0);
    check("rst_csr_waddr", {52'd0, csr_waddr}, 64'd0);
    check("rst_csr_wdata", csr_wdata, 64'd0);
    check("rst_redirect_pc", redirect_pc, 64'd0);
    check("rst_mtime", mtime, 64'd0);
    check("rst_mtip", {63'd0, mtip}, 64'd0);
    rst = 1'b0;

    // ecall
    inst_valid = 1'b1; is_ecall = 1'b1; pc = 64'h8000_0010;
    mstatus_in = 64'h8; mtvec_in = 64'h8000_1003;
    #1 check("ecall_T_stall", {63'd0, stall}, 64'd1);
    step(); clear_inputs();
    $display("[TB] ecall accepted pc=%h", pc);
    check("ecall_T1_wen", {63'd0, csr_wen}, 64'd1);
    check("ecall_T1_addr", {52'd0, csr_waddr}, 64'h341);
    check("ecall_T1_data", csr_wdata, 64'h8000_0010);
    check("ecall_T1_stall", {63'd0, stall}, 64'd1);
    step();
    check("ecall_T2_addr", {52'd0, csr_waddr}, 64'h342);
    check("ecall_T2_data", csr_wdata, 64'd11);
    step();
    check("ecall_T3_addr", {52'd0, csr_waddr}, 64'h300);
    check("ecall_T3_data", csr_wdata, 64'h1880);
    step();
    check("ecall_T4_redirect", {63'd0, redirect}, 64'd1);
    check("ecall_T4_pc", redirect_pc, 64'h8000_1000);
    check("ecall_T4_stall", {63'd0, stall}, 64'd1);
    check("ecall_T4_wen", {63'd0, csr_wen}, 64'd0);
    step();
    check("ecall_T5_redirect", {63'd0, redirect}, 64'd0);
    check("ecall_T5_stall", {63'd0, stall}, 64'd0);

    // mret
    inst_valid = 1'b1; is_mret = 1'b1; mstatus_in = 64'h1880; mepc_in = 64'h8000_0014;
    #1 check("mret_T_stall", {63'd0, stall}, 64'd1);
    step(); clear_inputs();
    $display("[TB] mret accepted mepc=%h", mepc_in);
    check("mret_T1_wen", {63'd0, csr_wen}, 64'd1);
    check("mret_T1_addr", {52'd0, csr_waddr}, 64'h300);
    check("mret_T1_data", csr_wdata, 64'h1888);
    step();
    check("mret_T2_redirect", {63'd0, redirect}, 64'd1);
    check("mret_T2_pc", redirect_pc, 64'h8000_0014);

    // Back-to-back: ecall+mret together right after JUMP -> ecall sequence
    step();
    inst_valid = 1'b1; is_ecall = 1'b1; is_mret = 1'b1; pc = 64'h8000_0020; mstatus_in = 64'h0;
    #1 check("both_T_stall", {63'd0, stall}, 64'd1);
    step(); clear_inputs();
    $display("[TB] ecall+mret accepted pc=%h", pc);
    check("both_T1_addr", {52'd0, csr_waddr}, 64'h341);
    check("both_T1_data", csr_wdata, 64'h8000_0020);
    step();
    check("both_T2_data", csr_wdata, 64'd11);
    step();
    check("both_T3_data", csr_wdata, 64'h1800);
    step();
    check("both_T4_pc", redirect_pc, 64'h8000_1000);

    // Timer interrupt: restart timer, compare value 5
    rst = 1'b1; step();
    rst = 1'b0; mtimecmp_wen = 1'b1; mtimecmp_wdata = 64'd5;
    step(); mtimecmp_wen = 1'b0;
    check("tmr_mtime1", mtime, 64'd1);
    repeat (4) step();
    check("tmr_mtime5", mtime, 64'd5);
    check("tmr_mtip_lo", {63'd0, mtip}, 64'd0);
    step();
    check("tmr_mtip_hi", {63'd0, mtip}, 64'd1);
    $display("[TB] mtimecmp=5 mtip rose at mtime=%0d", mtime);

    // mtip pending but MIE=0: no trap
    mie_mtie = 1'b1; mstatus_in = 64'h0; inst_valid = 1'b1; pc = 64'h8000_0030;
    #1 check("irq_mie0_stall", {63'd0, stall}, 64'd0);
    step(); clear_inputs();
    check("irq_mie0_wen", {63'd0, csr_wen}, 64'd0);
    check("irq_mie0_mtip", {63'd0, mtip}, 64'd1);

    // irq enabled but no inst_valid: nothing accepted
    mstatus_in = 64'h8;
    #1 check("irq_noinst_stall", {63'd0, stall}, 64'd0);

    // irq plus ecall: interrupt cause wins
    inst_valid = 1'b1; is_ecall = 1'b1; pc = 64'h8000_0040;
    #1 check("irq_T_stall", {63'd0, stall}, 64'd1);
    step(); clear_inputs();
    $display("[TB] irq accepted pc=%h", pc);
    check("irq_T1_data", csr_wdata, 64'h8000_0040);
    step();
    check("irq_T2_addr", {52'd0, csr_waddr}, 64'h342);
    check("irq_T2_cause", csr_wdata, 64'h8000_0000_0000_0007);
    step();
    check("irq_T3_data", csr_wdata, 64'h1880);
    step();
    check("irq_T4_pc", redirect_pc, 64'h8000_1000);
    mie_mtie = 1'b0;
    step();

    // Reset during CAUSE
    inst_valid = 1'b1; is_ecall = 1'b1; pc = 64'h8000_0050; mstatus_in = 64'h8;
    step(); clear_inputs();
    step();
    check("rstmid_cause_addr", {52'd0, csr_waddr}, 64'h342);
    rst = 1'b1;
    step();
    $display("[TB] reset applied during CAUSE");
    check("rstmid_wen", {63'd0, csr_wen}, 64'd0);
    check("rstmid_stall", {63'd0, stall}, 64'd0);
    check("rstmid_mtime", mtime, 64'd0);
    check("rstmid_mtip", {63'd0, mtip}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rstmid_redirect", {63'd0, redirect}, 64'd0);
      check("rstmid_wen_after", {63'd0, csr_wen}, 64'd0);
    end
    // mtimecmp back to all-ones, so mtime=8 still leaves mtip low
    check("rstmid_mtime8", mtime, 64'd8);
    check("rstmid_mtip_after", {63'd0, mtip}, 64'd0);

    // Prescaler with MTIME_DIV=4
    step(); rst_b = 1'b0;
    repeat (3) step();
    check("div4_mtime_3cyc", b_mtime, 64'd0);
    step();
    check("div4_mtime_4cyc", b_mtime, 64'd1);
    repeat (3) step();
    check("div4_mtime_7cyc", b_mtime, 64'd1);
    step();
    check("div4_mtime_8cyc", b_mtime, 64'd2);
    $display("[TB] div4 mtime after 8 cycles=%0d", b_mtime);

    // Wrap with 13-bit timer and mtimecmp=0
    rst_c = 1'b0; c_wen = 1'b1; c_wdata = 13'd0;
    step(); c_wen = 1'b0;
    check("wrap_start", {51'd0, c_mtime}, 64'd1);
    repeat (8190) step();
    check("wrap_allones", {51'd0, c_mtime}, 64'h1FFF);
    check("wrap_mtip_pre", {63'd0, c_mtip}, 64'd1);
    step();
    check("wrap_zero", {51'd0, c_mtime}, 64'd0);
    check("wrap_mtip_at0", {63'd0, c_mtip}, 64'd1);
    step();
    check("wrap_mtip_after", {63'd0, c_mtip}, 64'd1);
    $display("[TB] mtime wrapped to %0d", c_mtime);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Multi-cycle trap sequencer for the npc core's machine-mode CSR file.
- Owns the machine timer (mtime/mtimecmp) and decides when to take a timer interrupt or an ecall trap, or to execute mret.
- Drives the CSR file's single write port one register per cycle (mepc, mcause, mstatus), stalls the core while sequencing, then redirects the PC.
- Sits between decode/retire and the CSR register file.

Parameters:
- XLEN, 64, datapath width.
- MTIME_DIV, 1, clock cycles per mtime increment (>=1).
- MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- inst_valid  in  1  instruction at pc retires this cycle
- pc  in  XLEN  PC of that instruction
- is_ecall  in  1  instruction is ecall
- is_mret  in  1  instruction is mret
- mstatus_in  in  XLEN  current mstatus from CSR file
- mie_mtie  in  1  mie.MTIE
- mtvec_in  in  XLEN  current mtvec
- mepc_in  in  XLEN  current mepc
- mtimecmp_wen  in  1  write mtimecmp
- mtimecmp_wdata  in  XLEN  new mtimecmp
- stall  out  1  freeze PC/regfile writes
- redirect  out  1  load redirect_pc into PC
- redirect_pc  out  XLEN  target PC
- csr_wen  out  1  CSR write strobe
- csr_waddr  out  12  CSR address
- csr_wdata  out  XLEN  CSR write data
- mtime  out  XLEN  timer value
- mtip  out  1  timer interrupt pending (registered)

Behaviour:
- Clock clk, reset rst: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; stall=0; redirect=0; csr_wen=0; csr_waddr=0; csr_wdata=0; redirect_pc=0; mtime=0; prescaler=0; mtimecmp=MTIMECMP_RST; mtip=0.
- Timer:
  - Prescaler counts 0..MTIME_DIV-1; mtime increments by 1 when the prescaler equals MTIME_DIV-1.
  - mtime wraps from all-ones to 0.
  - mtimecmp loads mtimecmp_wdata on mtimecmp_wen.
  - mtip <= (mtime >= mtimecmp), unsigned, using the current-cycle register values. A compare-write is therefore reflected in mtip two cycles later.
- irq = mtip & mie_mtie & mstatus_in[3].
- States: IDLE, EPC, CAUSE, STATUS, MRET_ST, JUMP.
- IDLE acceptance, when inst_valid=1:
  - Priority is irq > is_ecall > is_mret; is_ecall and is_mret both high is treated as ecall.
  - On irq: latch saved_pc=pc and saved_cause=64'h8000_0000_0000_0007, go to EPC.
  - On ecall: latch saved_pc=pc and saved_cause=64'd11, go to EPC.
  - On mret: go to MRET_ST.
  - stall=1 combinationally in the accepting cycle.
  - Without inst_valid, nothing is accepted and irq stays pending.
- EPC: csr_wen=1, addr 12'h341, data saved_pc. Next state CAUSE.
- CAUSE: csr_wen=1, addr 12'h342, data saved_cause. Next state STATUS.
- STATUS: csr_wen=1, addr 12'h300. Data = mstatus_in with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11, other bits unchanged. Next state JUMP with target mtvec_in sampled this cycle, low 2 bits forced to 0.
- MRET_ST: csr_wen=1, addr 12'h300. Data = mstatus_in with MIE[3]=MPIE[7], MPIE[7]=1, MPP[12:11]=2'b11. Next state JUMP with target mepc_in sampled this cycle.
- JUMP: redirect=1 and redirect_pc=target for exactly one cycle, stall=1, csr_wen=0. Next state IDLE.
- stall=1 in every non-IDLE state. At most one csr_wen per cycle.
- Latency from acceptance cycle T:
  - Trap: CSR writes at T+1, T+2, T+3; redirect at T+4.
  - mret: CSR write at T+1; redirect at T+2.
- All inputs other than mstatus_in, mtvec_in, mepc_in and the mtimecmp port are ignored while not IDLE.
- Back-to-back: a new event can be accepted in the cycle immediately after JUMP.
- Reset mid-sequence: return to IDLE next edge; no further csr_wen or redirect; timer state reinitialised.

Test Plan:
- ecall: pc=0x8000_0010, inst_valid=1, is_ecall=1, mstatus_in=0x8, mtvec_in=0x8000_1003 -> T+1 write 0x341=0x8000_0010; T+2 write 0x342=11; T+3 write 0x300=0x1880; T+4 redirect to 0x8000_1000; stall high T..T+4.
- mret: mstatus_in=0x1880, mepc_in=0x8000_0014 -> T+1 write 0x300=0x1888; T+2 redirect to 0x8000_0014.
- Timer interrupt with MTIME_DIV=1, mtimecmp write 5, mie_mtie=1, mstatus_in[3]=1 -> mtip rises the cycle after mtime reaches 5. Next inst_valid takes the trap with cause 0x8000_0000_0000_0007. With mstatus_in[3]=0 there is no trap, but mtip stays high.
- Priority: irq pending plus is_ecall in the same cycle -> mcause is the interrupt cause. is_ecall and is_mret together -> ecall sequence.
- Prescaler and wrap with MTIME_DIV=4 -> mtime increments once per 4 cycles. Force mtimecmp=0 and run mtime to all-ones -> next increment gives 0, mtip stays 1.
- Reset asserted during CAUSE -> next cycle state IDLE, csr_wen=0, stall=0, redirect never asserted, mtime=0, mtimecmp=all-ones.
